flash_line_cache: RTL

- Direct-mapped, read-only line cache between the CPU memory bus and the SPI flash reader; serves instruction and data fetches to the flash window (mem_addr[31:24] == 8'h00).
- A miss triggers one multi-word burst on the flash reader (word_count = LINE_WORDS) that fills a whole line. Hits return in one cycle instead of a full SPI transaction.
- Sits directly upstream of the flash reader and consumes its strobe/data stream. The SoC address decoder gates cpu_valid.

---
 rtl/flash_line_cache.sv | 137 +++++++++++++
 1 files changed

// File: rtl/flash_line_cache.sv
// Direct-mapped read-only line cache in front of the SPI flash reader.
// A miss fetches a whole line as one burst; hits answer in a single cycle.
module flash_line_cache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [23:0] cpu_addr,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        sfr_start,
    output logic [23:0] sfr_address,
    output logic [23:0] sfr_word_count,
    input  logic        sfr_strobe,
    input  logic [31:0] sfr_data_in
);

    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 22 - OFF - IDX;
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    //  state | meaning
    //  IDLE  | waiting for a request; hits are answered from here
    //  FILL  | burst running, collecting flash words into the line
    //  RESP  | line complete, returning the requested word
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES][LINE_WORDS];

    logic [OFF-1:0]   cnt;
    logic [OFF-1:0]   req_off;
    logic [IDX-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [OFF-1:0]   cpu_off;
    logic [IDX-1:0]   cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             lookup_hit;
    logic             accept;
    logic             fill_write;
    logic             fill_last;
    logic             unused_bits;

    assign cpu_off        = cpu_addr[OFF+1:2];
    assign cpu_idx        = cpu_addr[OFF+IDX+1:OFF+2];
    assign cpu_tag        = cpu_addr[23:OFF+IDX+2];
    assign lookup_hit     = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign sfr_word_count = 24'(LINE_WORDS);
    assign unused_bits    = ^cpu_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fill_write = 1'b0;
        fill_last  = 1'b0;
        case (state)
            IDLE: begin
                // the ready cycle itself never re-accepts a held request
                if (cpu_valid && !cpu_ready) begin
                    accept = 1'b1;
                    if (!lookup_hit) state_next = FILL;
                end
            end
            FILL: begin
                if (sfr_strobe) begin
                    fill_write = 1'b1;
                    if (cnt == LAST_WORD) begin
                        fill_last  = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            sfr_start   <= 1'b0;
            sfr_address <= '0;
            valid       <= '0;
            cnt         <= '0;
            req_off     <= '0;
            req_idx     <= '0;
            req_tag     <= '0;
        end else begin
            cpu_ready <= 1'b0;
            sfr_start <= 1'b0;
            if (accept && lookup_hit) begin
                cpu_ready <= 1'b1;
                cpu_rdata <= data[cpu_idx][cpu_off];
            end
            if (accept && !lookup_hit) begin
                req_off     <= cpu_off;
                req_idx     <= cpu_idx;
                req_tag     <= cpu_tag;
                sfr_start   <= 1'b1;
                sfr_address <= {cpu_tag, cpu_idx, {(OFF + 2){1'b0}}};
                cnt         <= '0;
            end
            if (fill_write) cnt <= cnt + 1'b1;
            if (fill_last) begin
                valid[req_idx] <= 1'b1;
                cpu_ready      <= 1'b1;
                // the requested word may be the one arriving right now
                cpu_rdata      <= (cnt == req_off) ? sfr_data_in : data[req_idx][req_off];
            end
            if (flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_write) data[req_idx][cnt] <= sfr_data_in;
        if (!reset && fill_last)  tags[req_idx] <= req_tag;
    end

endmodule
